dmem_arbiter: RTL

//  Two-port arbiter and sequencer in front of the single-port 4 KB byte-addressed data memory.

---
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signal bundle for the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  // Port A: CPU load/store path
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  // Port B: secondary master (loader/debug/DMA)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  // Single-port memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wrEn;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done, b_err, b_rdata,
    output mem_addr, mem_wrEn, mem_wdata,
    input  mem_rdata,
    output busy
  );

  // Requester/memory view
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done, b_err, b_rdata,
    input  mem_addr, mem_wrEn, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data memory.
// One word transaction at a time: IDLE -> CMD -> [WAIT x RD_LAT, aligned reads] -> DONE -> IDLE.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic              last_b_q,  last_b_d;
  logic              win_b_q,   win_b_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_gnt_q,   a_gnt_d;
  logic              b_gnt_q,   b_gnt_d;
  logic              a_done_q,  a_done_d;
  logic              b_done_q,  b_done_d;
  logic              a_err_q,   a_err_d;
  logic              b_err_q,   b_err_d;
  logic              wr_en_q,   wr_en_d;
  logic              busy_q,    busy_d;

  logic              pick_b_c;
  logic              aligned_c;
  logic              mis_d_c;

  // B wins when it is the only requester, or on a tie when A was served last
  assign pick_b_c  = bus.b_req && (!bus.a_req || !last_b_q);
  assign aligned_c = (addr_q[1:0] == 2'b00);
  assign mis_d_c   = (addr_d[1:0] != 2'b00);

  // Next-state, latched transaction and registered-output computation
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    win_b_d   = win_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          win_b_d  = pick_b_c;
          last_b_d = pick_b_c;
          we_d     = pick_b_c ? bus.b_we    : bus.a_we;
          addr_d   = pick_b_c ? bus.b_addr  : bus.a_addr;
          wdata_d  = pick_b_c ? bus.b_wdata : bus.a_wdata;
          state_d  = S_CMD;
        end
      end
      S_CMD: begin
        if (aligned_c && !we_q) begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end else begin
          // Misaligned read returns zero; writes leave read data untouched
          if (!aligned_c && !we_q) begin
            if (win_b_q) b_rdata_d = '0;
            else         a_rdata_d = '0;
          end
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (win_b_q) b_rdata_d = bus.mem_rdata;
          else         a_rdata_d = bus.mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    a_gnt_d  = (state_d == S_CMD)  && !win_b_d;
    b_gnt_d  = (state_d == S_CMD)  &&  win_b_d;
    a_done_d = (state_d == S_DONE) && !win_b_d;
    b_done_d = (state_d == S_DONE) &&  win_b_d;
    a_err_d  = a_done_d && mis_d_c;
    b_err_d  = b_done_d && mis_d_c;
    wr_en_d  = (state_d == S_CMD) && we_d && !mis_d_c;
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.a_gnt     = a_gnt_q;
  assign bus.a_done    = a_done_q;
  assign bus.a_err     = a_err_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.b_done    = b_done_q;
  assign bus.b_err     = b_err_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wrEn  = wr_en_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule
